// File: rtl/mul_pipe_vr_if.sv
// Valid/ready handshake bundle for the pipelined multiplier: operand side
// (in_valid/in_ready/a/b/is_signed) and result side (out_valid/out_ready/z).
interface mul_pipe_vr_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/mul_pipe_vr.sv
// Three-stage valid/ready multiplier: S1 splits the partial-product rows into
// two sums, S2 combines them, S3 is the output register. One global stall.
module mul_pipe_vr #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_pipe_vr_if.slave  bus
);
  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;

  logic                     en;
  logic [W2-1:0]            a_ext;
  logic [W2-1:0]            neg_a_ext;
  logic [W-1:0][W2-1:0]     rows;
  logic [W2-1:0]            p_lo_next;
  logic [W2-1:0]            p_hi_next;

  logic [W2-1:0]            p_lo_reg;
  logic [W2-1:0]            p_hi_reg;
  logic                     s1_valid_reg;
  logic [W2-1:0]            prod_reg;
  logic                     s2_valid_reg;
  logic [W2-1:0]            z_reg;
  logic                     out_valid_reg;

  assign en           = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_reg;
  assign bus.z         = z_reg;

  assign a_ext     = bus.is_signed ? {{W{bus.a[W-1]}}, bus.a} : {{W{1'b0}}, bus.a};
  assign neg_a_ext = -a_ext;

  // Signed operands: the multiplier MSB carries weight -2^(W-1), so its row
  // adds the negated multiplicand; everything else is plain shift-and-add.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_row
      if (gi == W - 1) begin : g_msb
        assign rows[gi] = !bus.b[gi]    ? '0 :
                          bus.is_signed ? (neg_a_ext << gi) : (a_ext << gi);
      end else begin : g_low
        assign rows[gi] = bus.b[gi] ? (a_ext << gi) : '0;
      end
    end
  endgenerate

  always_comb begin
    p_lo_next = '0;
    p_hi_next = '0;
    for (int i = 0; i < W / 2; i++) begin
      p_lo_next = p_lo_next + rows[i];
    end
    for (int i = W / 2; i < W; i++) begin
      p_hi_next = p_hi_next + rows[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_lo_reg      <= '0;
      p_hi_reg      <= '0;
      s1_valid_reg  <= 1'b0;
      prod_reg      <= '0;
      s2_valid_reg  <= 1'b0;
      z_reg         <= '0;
      out_valid_reg <= 1'b0;
    end else if (en) begin
      p_lo_reg      <= p_lo_next;
      p_hi_reg      <= p_hi_next;
      s1_valid_reg  <= bus.in_valid;
      prod_reg      <= p_lo_reg + p_hi_reg;
      s2_valid_reg  <= s1_valid_reg;
      z_reg         <= prod_reg;
      out_valid_reg <= s2_valid_reg;
    end
  end
endmodule

// File: tb/tb_mul_pipe_vr.sv
// Randomized and directed bench for mul_pipe_vr; an arithmetic model feeds a
// queue of expected products that a negedge monitor drains in order.
module tb_mul_pipe_vr;
  localparam int W = 8;

  logic clk;
  logic rst_n;

  mul_pipe_vr_if #(.WIDTH(W)) bus ();

  mul_pipe_vr #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint px;
    longint py;
    longint p;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    p  = px * py;
    return p[2*W-1:0];
  endfunction

  // Scoreboard: inputs sampled mid-cycle are exactly those seen at the next edge.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_result", bus.out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("z_order", bus.z, e);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_mul(bus.a, bus.b, bus.is_signed));
        n_acc++;
      end
    end
  end

  task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input logic [2*W-1:0] exp_z, input string tag);
    int lat;
    bus.a = ta; bus.b = tb_v; bus.is_signed = ts;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_z"}, bus.z, exp_z);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0]   sa[4];
    logic [W-1:0]   sb[4];
    logic           ss[4];
    logic [2*W-1:0] sz[4];
    logic [7:0]     ov;
    logic [2*W-1:0] zs[8];
    logic [2*W-1:0] z_hold;
    int             cyc;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_z", bus.z, 16'h0000);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // First transfer lands on the first edge after release.
    rst_n = 1'b1;
    send_one(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_255x255");
    send_one(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_sq");
    send_one(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_m1x1");
    send_one(8'hFF, 8'h01, 1'b0, 16'h00FF, "u_255x1");

    // Back-to-back stream: four results on four consecutive cycles.
    sa = '{8'd3, 8'h7F, 8'd0, 8'd16};
    sb = '{8'd5, 8'h81, 8'd200, 8'd16};
    ss = '{1'b0, 1'b1, 1'b0, 1'b0};
    sz = '{16'h000F, 16'hC0FF, 16'h0000, 16'h0100};
    ov = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        bus.a = sa[i]; bus.b = sb[i]; bus.is_signed = ss[i]; bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      ov[i] = bus.out_valid;
      zs[i] = bus.z;
    end
    check("stream_valid_pattern", ov, 8'h3C);
    for (int i = 0; i < 4; i++) check($sformatf("stream_z%0d", i), zs[i+2], sz[i]);

    // Backpressure: three in flight, five stalled cycles, then drain.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.a = W'(8'd10 + i); bus.b = W'(8'hF0 + i); bus.is_signed = i[0];
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.a = 8'h55; bus.b = 8'h66;
    z_hold = bus.z;
    check("stall_first_z", z_hold, ref_mul(8'd10, 8'hF0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", bus.out_valid, 1'b1);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_z_hold", bus.z, z_hold);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stall_drained", exp_q.size(), 0);

    // Reset with two transactions in flight.
    bus.a = 8'h12; bus.b = 8'h34; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = 8'h9A; bus.b = 8'hBC;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_out_valid", bus.out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_z", bus.z, 16'h0000);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_stale", bus.out_valid, 1'b0);
    end

    // Random traffic with random backpressure.
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 40000) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.is_signed = 1'($urandom);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("random_accept_count", n_acc, 10000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("random_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
